// File: rtl/tap_generator.sv
// Tap burst generator: emits N active-high pulses of HIGH_CYCLES/LOW_CYCLES width,
// then a quiet GAP_CYCLES tail, then a one-clock done pulse.
module tap_generator #(
    parameter int COUNT_WIDTH = 8,
    parameter int HIGH_CYCLES = 120_000,
    parameter int LOW_CYCLES  = 120_000,
    parameter int GAP_CYCLES  = 12_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic                   busy,
    output logic                   tap_out,
    output logic [COUNT_WIDTH-1:0] taps_sent,
    output logic                   done
);

    localparam int MAX_HL   = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int MAX_ALL  = (MAX_HL > GAP_CYCLES) ? MAX_HL : GAP_CYCLES;
    localparam int TIMER_W  = $clog2(MAX_ALL + 1);

    localparam logic [TIMER_W-1:0] H_LOAD = TIMER_W'(HIGH_CYCLES);
    localparam logic [TIMER_W-1:0] L_LOAD = TIMER_W'(LOW_CYCLES);
    localparam logic [TIMER_W-1:0] G_LOAD = TIMER_W'(GAP_CYCLES);
    localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] taps_q, taps_d;
    logic [COUNT_WIDTH-1:0] taps_inc;
    logic                   tap_q, tap_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   expired;

    assign busy      = busy_q;
    assign tap_out   = tap_q;
    assign taps_sent = taps_q;
    assign done      = done_q;

    // Timer is loaded with the full segment length and the segment ends on the
    // edge where it reads 1, so each level lasts exactly the programmed clocks.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        taps_d   = taps_q;
        tap_d    = tap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        taps_inc = taps_q + COUNT_WIDTH'(1);
        expired  = (timer_q == T_ONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = count_in;
                    taps_d  = '0;
                    if (count_in != '0) begin
                        state_d = S_HIGH;
                        timer_d = H_LOAD;
                        tap_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (expired) begin
                    taps_d = taps_inc;
                    tap_d  = 1'b0;
                    if (taps_inc == count_q) begin
                        state_d = S_GAP;
                        timer_d = G_LOAD;
                    end else begin
                        state_d = S_LOW;
                        timer_d = L_LOAD;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_LOW: begin
                if (expired) begin
                    state_d = S_HIGH;
                    timer_d = H_LOAD;
                    tap_d   = 1'b1;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_GAP: begin
                if (expired) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            count_q <= '0;
            taps_q  <= '0;
            tap_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            taps_q  <= taps_d;
            tap_q   <= tap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tap_generator.sv
// Directed bench for tap_generator with H=3, L=2, G=10; waveforms captured per
// cycle into bit vectors and compared against hand-derived patterns.
module tb_tap_generator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] count_in;
    logic       busy;
    logic       tap_out;
    logic [7:0] taps_sent;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    tap_generator #(
        .COUNT_WIDTH(8),
        .HIGH_CYCLES(3),
        .LOW_CYCLES (2),
        .GAP_CYCLES (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count_in (count_in),
        .busy     (busy),
        .tap_out  (tap_out),
        .taps_sent(taps_sent),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit c of each vector is the output level in cycle c+1 after the start edge.
    task automatic run_burst(input int n, input int ncyc, input bit disturb,
                             output logic [63:0] tw, output logic [63:0] bw,
                             output logic [63:0] dw, output logic [7:0] ts_mid);
        tw = '0;
        bw = '0;
        dw = '0;
        ts_mid = '0;
        @(negedge clk);
        start    = 1'b1;
        count_in = n[7:0];
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) start = 1'b0;
            if (disturb && c == 3) begin
                start    = 1'b1;
                count_in = 8'd7;
            end
            if (disturb && c == 5) start = 1'b0;
            if (disturb && c == 8) count_in = 8'd200;
            tw[c] = tap_out;
            bw[c] = busy;
            dw[c] = done;
            if (c == 4) ts_mid = taps_sent;
        end
    endtask

    task automatic wait_done(input int bound, output int cyc, output int rises);
        logic prev;
        bit   seen;
        cyc   = 0;
        rises = 0;
        seen  = 1'b0;
        prev  = tap_out;
        while (!seen && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tap_out && !prev) rises++;
            prev = tap_out;
            if (done) seen = 1'b1;
        end
    endtask

    logic [63:0] tw, bw, dw;
    logic [7:0]  ts_mid;
    logic [10:0] acc;
    int          cyc, rises;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        count_in = '0;

        // Start pulses while held in reset must do nothing
        repeat (3) begin
            @(negedge clk);
            start    = 1'b1;
            count_in = 8'd5;
        end
        @(posedge clk);
        #1;
        check_eq("rst_tap",   tap_out,   0);
        check_eq("rst_busy",  busy,      0);
        check_eq("rst_done",  done,      0);
        check_eq("rst_taps",  taps_sent, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        acc = '0;
        repeat (50) begin
            @(posedge clk);
            #1;
            acc = acc | {tap_out, busy, done, taps_sent};
        end
        check_eq("idle50_quiet", acc, 0);

        // N=3: taps in cycles 1-3, 6-8, 11-13; busy 1-23; done 24
        run_burst(3, 24, 1'b0, tw, bw, dw, ts_mid);
        check_eq("n3_tap",  tw, 64'h1CE7);
        check_eq("n3_busy", bw, 64'h7F_FFFF);
        check_eq("n3_done", dw, 64'h80_0000);
        check_eq("n3_taps_mid", ts_mid, 1);
        check_eq("n3_taps_end", taps_sent, 3);
        @(posedge clk);
        #1;
        check_eq("n3_after_done", done, 0);
        check_eq("n3_taps_hold", taps_sent, 3);

        // N=0: only a done pulse in cycle 1
        run_burst(0, 4, 1'b0, tw, bw, dw, ts_mid);
        check_eq("n0_tap",  tw, 0);
        check_eq("n0_busy", bw, 0);
        check_eq("n0_done", dw, 64'h1);
        check_eq("n0_taps", taps_sent, 0);

        // N=2 with start/count_in disturbance mid-burst: taps 1-3, 6-8; busy 1-18; done 19
        run_burst(2, 19, 1'b1, tw, bw, dw, ts_mid);
        check_eq("dist_tap",  tw, 64'hE7);
        check_eq("dist_busy", bw, 64'h3_FFFF);
        check_eq("dist_done", dw, 64'h4_0000);
        check_eq("dist_taps", taps_sent, 2);

        // Chain: start during the done cycle with N=1
        start    = 1'b1;
        count_in = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("chain_tap",  tap_out,   1);
        check_eq("chain_busy", busy,      1);
        check_eq("chain_done", done,      0);
        check_eq("chain_taps", taps_sent, 0);
        wait_done(50, cyc, rises);
        check_eq("chain_done_cyc", cyc, 13);
        check_eq("chain_taps_end", taps_sent, 1);

        // Reset in the 2nd HIGH of an N=5 burst
        @(negedge clk);
        start    = 1'b1;
        count_in = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_pre_tap",  tap_out,   1);
        check_eq("abort_pre_taps", taps_sent, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_tap",  tap_out,   0);
        check_eq("abort_busy", busy,      0);
        check_eq("abort_taps", taps_sent, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = '0;
        repeat (60) begin
            @(posedge clk);
            #1;
            acc = acc | {tap_out, busy, done, taps_sent};
        end
        check_eq("abort_no_done", acc, 0);

        run_burst(2, 19, 1'b0, tw, bw, dw, ts_mid);
        check_eq("post_tap",  tw, 64'hE7);
        check_eq("post_busy", bw, 64'h3_FFFF);
        check_eq("post_done", dw, 64'h4_0000);
        check_eq("post_taps", taps_sent, 2);

        // N=255: done in cycle 255*3 + 254*2 + 10 + 1 = 1284
        @(negedge clk);
        start    = 1'b1;
        count_in = 8'd255;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("max_first_tap", tap_out, 1);
        wait_done(2000, cyc, rises);
        check_eq("max_done_cyc", cyc, 1283);
        check_eq("max_rises",    rises + 1, 255);
        check_eq("max_taps",     taps_sent, 255);
        check_eq("max_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
